alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational N-bit ALU (ports A, B, SEL[3:0] in; SUM, CarryOut out) between two requesters.
- Each requester issues an operation over a valid/ready handshake. The block arbitrates round-robin, drives the ALU from registered operands, and captures SUM/CarryOut.
- Returns the result with the requester ID over a valid/ready response channel.
- Sits between the ALU instance and its clients; it is the only driver of the ALU inputs.

Parameters:
- N, 8: ALU operand and result width.
- CNT_W, 16: width of each per-requester completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  N each  requester 0 operands.
- req0_sel  in  4  requester 0 ALU opcode, passed through unmodified.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as requester 0, for requester 1.
- A  out  N  to ALU A.
- B  out  N  to ALU B.
- SEL  out  4  to ALU SEL.
- SUM  in  N  from ALU.
- CarryOut  in  1  from ALU.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester that issued the result.
- rsp_sum  out  N  captured SUM.
- rsp_carry  out  1  captured CarryOut.
- busy  out  1  high in any state other than IDLE.
- cnt0, cnt1  out  CNT_W each  completed operations per requester.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - State IDLE; last_grant = 1, so requester 0 wins the first contention.
  - A, B, SEL, rsp_sum, rsp_carry, rsp_id, cnt0, cnt1 = 0.
  - rsp_valid = 0, busy = 0, req0_ready = req1_ready = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant logic is combinational. With only one valid request, that requester wins. With both valid, the requester that is not last_grant wins.
  - The winner's reqX_ready = 1 in this cycle, only in IDLE. The loser's ready stays 0.
  - On the edge: A/B/SEL <= winner's a/b/sel, gnt_id <= winner, last_grant <= winner, next state EXEC.
  - No valid request: remain in IDLE. A/B/SEL hold their previous values.
- EXEC:
  - The ALU settles from the registered A/B/SEL.
  - On the edge: rsp_sum <= SUM, rsp_carry <= CarryOut, rsp_id <= gnt_id, next state RESP.
  - Always exactly one cycle.
- RESP:
  - rsp_valid = 1.
  - If rsp_ready = 1: increment cnt[rsp_id] on that edge and return to IDLE.
  - Otherwise hold; rsp_* stay stable while rsp_valid = 1.
- Latency: acceptance cycle to first rsp_valid cycle = 2 cycles. Maximum throughput = 1 operation per 3 cycles.
- No new request is accepted while busy. Requesters must hold valid and payload stable until ready.
- Counters saturate at all-ones and do not wrap.
- Simultaneous events:
  - rsp_ready in RESP and a pending request: the request is accepted on the following IDLE cycle, not in the same cycle.
  - Both valid on consecutive operations: grants alternate 0, 1, 0, 1.
- Reset mid-operation (EXEC or RESP): the in-flight result is dropped and its counter is not incremented. All reset values apply on the next cycle.
- Opcode semantics belong to the ALU. This block never decodes SEL.

Decomposition:
- Shared package alu_pkg:
  - State encoding constants ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2.
  - SEL_W = 4.
  - Default ALU width N = 8.
- One natural sub-module, rr_arb2: a two-way round-robin grant. Inputs: valid pair, last_grant. Outputs: one-hot grant.
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
- Single op: after reset, req0 a=0x05, b=0x03, sel=0000, rsp_ready held 1.
  - req0_ready=1 in cycle 0, A=0x05/B=0x03/SEL=0000 from cycle 1.
  - rsp_valid=1 in cycle 2, with rsp_id=0, rsp_sum = the ALU's SUM for those inputs, cnt0=1 after.
- Contention: req0 and req1 valid together from reset, 4 ops total.
  - Grant order 0, 1, 0, 1; rsp_id sequence matches.
  - cnt0=2, cnt1=2; each request is accepted 3 cycles apart.
- Response backpressure: rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid and rsp_sum/rsp_carry/rsp_id stable for all 5 cycles; busy=1.
  - No req*_ready asserted; the counter is unchanged until the rsp_ready cycle.
- Carry capture: req1 a=0xFF, b=0x01 with the ALU's add opcode.
  - rsp_sum=0x00, rsp_carry=1, rsp_id=1.
- Reset mid-op: assert rst during EXEC.
  - Next cycle: IDLE, rsp_valid=0, A/B/SEL=0, cnt0/cnt1=0.
  - After release, requester 0 wins the first contention.
- Saturation: with CNT_W=2, complete 5 ops from req0.
  - cnt0=3 after the 3rd op and stays 3.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and FSM state type for the ALU arbiter
package alu_pkg;
  localparam int SEL_W = 4;
  localparam int ALU_W = 8;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin one-hot grant favouring the requester not granted last
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] gnt
);
  assign gnt[0] = valid[0] & (~valid[1] | last_grant);
  assign gnt[1] = valid[1] & (~valid[0] | ~last_grant);
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two valid/ready requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N     = ALU_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  input  logic [SEL_W-1:0] req1_sel,
  output logic [N-1:0]     A,
  output logic [N-1:0]     B,
  output logic [SEL_W-1:0] SEL,
  input  logic [N-1:0]     SUM,
  input  logic             CarryOut,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [N-1:0]     rsp_sum,
  output logic             rsp_carry,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  state_t state, state_nx;
  logic [1:0] gnt;
  logic gnt_id, last_grant, accept, done;
  rr_arb2 u_arb (.valid({req1_valid, req0_valid}), .last_grant(last_grant), .gnt(gnt));
  always_comb begin
    accept = (state == ST_IDLE) & |gnt;
    done = (state == ST_RESP) & rsp_ready;
    state_nx = accept ? ST_EXEC : state == ST_EXEC ? ST_RESP : done ? ST_IDLE : state;
    req0_ready = ~rst & accept & gnt[0];
    req1_ready = ~rst & accept & gnt[1];
    rsp_valid = state == ST_RESP;
    busy = state != ST_IDLE;
  end
  always_ff @(posedge clk)
    state <= rst ? ST_IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      A <= '0;
      B <= '0;
      SEL <= '0;
      gnt_id <= 1'b0;
      last_grant <= 1'b1;
      rsp_sum <= '0;
      rsp_carry <= 1'b0;
      rsp_id <= 1'b0;
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (accept) begin
        A <= gnt[1] ? req1_a : req0_a;
        B <= gnt[1] ? req1_b : req0_b;
        SEL <= gnt[1] ? req1_sel : req0_sel;
        gnt_id <= gnt[1];
        last_grant <= gnt[1];
      end
      if (state == ST_EXEC) begin
        rsp_sum <= SUM;
        rsp_carry <= CarryOut;
        rsp_id <= gnt_id;
      end
      if (done && !rsp_id && !(&cnt0)) cnt0 <= cnt0 + CNT_W'(1);
      if (done && rsp_id && !(&cnt1)) cnt1 <= cnt1 + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random self-checking bench for alu_arbiter
module tb_alu_arbiter;
  logic clk, rst, req0_valid, req1_valid, rsp_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_sel, req1_sel;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carry, busy, CarryOut;
  logic [7:0] A, B, SUM, rsp_sum;
  logic [3:0] SEL;
  logic [15:0] cnt0, cnt1;
  logic s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_carry, s_busy, s_co;
  logic [7:0] s_a, s_b, s_sum, s_rsp_sum;
  logic [3:0] s_sel;
  logic [1:0] s_cnt0, s_cnt1;
  int total = 0, bad = 0;
  bit pv [2];
  logic [7:0] pa [2], pb [2];
  logic [3:0] ps [2];
  int cnt [2];
  bit last;
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    case (s)
      4'd0: return {1'b0, a} + {1'b0, b};
      4'd1: return {1'b0, a} - {1'b0, b};
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction
  always_comb {CarryOut, SUM} = alu_f(A, B, SEL);
  always_comb {s_co, s_sum} = alu_f(s_a, s_b, s_sel);
  alu_arbiter #(.N(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .A(A), .B(B), .SEL(SEL), .SUM(SUM), .CarryOut(CarryOut),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );
  alu_arbiter #(.N(8), .CNT_W(2)) sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .A(s_a), .B(s_b), .SEL(s_sel), .SUM(s_sum), .CarryOut(s_co),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_sum(s_rsp_sum), .rsp_carry(s_rsp_carry),
    .busy(s_busy), .cnt0(s_cnt0), .cnt1(s_cnt1)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt0"}, cnt0, cnt[0]);
    chk({tag, "_cnt1"}, cnt1, cnt[1]);
    chk({tag, "_sat0"}, s_cnt0, cnt[0] > 3 ? 3 : cnt[0]);
    chk({tag, "_sat1"}, s_cnt1, cnt[1] > 3 ? 3 : cnt[1]);
  endtask
  task automatic drive();
    req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_sel = ps[0];
    req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_sel = ps[1];
  endtask
  task automatic op(input bit n0, input bit n1, input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] s0,
                    input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] s1, input int stall);
    bit w;
    logic [8:0] r;
    if (n0 && !pv[0]) begin pv[0] = 1; pa[0] = a0; pb[0] = b0; ps[0] = s0; end
    if (n1 && !pv[1]) begin pv[1] = 1; pa[1] = a1; pb[1] = b1; ps[1] = s1; end
    drive();
    rsp_ready = 0;
    #1;
    w = (pv[0] && pv[1]) ? !last : pv[1];
    r = alu_f(pa[w], pb[w], ps[w]);
    chk("idle_ready0", req0_ready, w == 0);
    chk("idle_ready1", req1_ready, w == 1);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    chk("exec_A", A, pa[w]);
    chk("exec_B", B, pb[w]);
    chk("exec_SEL", SEL, ps[w]);
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_ready", {req1_ready, req0_ready}, 0);
    pv[w] = 0;
    drive();
    @(negedge clk);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_id", rsp_id, w);
    chk("resp_sum", rsp_sum, r[7:0]);
    chk("resp_carry", rsp_carry, r[8]);
    chk("resp_ready", {req1_ready, req0_ready}, 0);
    rsp_ready = stall == 0;
    for (int i = 1; i <= stall; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_busy", busy, 1);
      chk("hold_rsp", {rsp_id, rsp_carry, rsp_sum}, {w, r});
      chk("hold_ready", {req1_ready, req0_ready}, 0);
      chk_cnt("hold");
      if (i == stall) rsp_ready = 1;
    end
    @(negedge clk);
    rsp_ready = 0;
    cnt[w]++;
    last = w;
    chk("done_busy", busy, 0);
    chk("done_rsp_valid", rsp_valid, 0);
    chk_cnt("done");
  endtask
  initial begin
    bit n0, n1;
    rst = 1; rsp_ready = 0;
    pv = '{0, 0}; pa = '{8'h0, 8'h0}; pb = '{8'h0, 8'h0}; ps = '{4'h0, 4'h0};
    drive();
    req0_valid = 1; req1_valid = 1;
    cnt = '{0, 0}; last = 1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_abs", {A, B, SEL}, 0);
    chk("rst_rsp", {rsp_id, rsp_carry, rsp_sum}, 0);
    chk_cnt("rst");
    rst = 0;
    op(1, 0, 8'h05, 8'h03, 4'h0, 8'h0, 8'h0, 4'h0, 0);
    repeat (4) op(1, 1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 5)),
                  8'($urandom), 8'($urandom), 4'($urandom_range(0, 5)), 0);
    op(1, 0, 8'h9C, 8'h77, 4'h1, 8'h0, 8'h0, 4'h0, 5);
    op(0, 1, 8'h0, 8'h0, 4'h0, 8'hFF, 8'h01, 4'h0, 0);
    for (int k = 0; k < 30; k++) begin
      n0 = 1'($urandom_range(0, 1));
      n1 = 1'($urandom_range(0, 1));
      if (!n0 && !n1 && !pv[0] && !pv[1]) n0 = 1;
      op(n0, n1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 6)),
         8'($urandom), 8'($urandom), 4'($urandom_range(0, 6)), $urandom_range(0, 2));
    end
    while (pv[0] || pv[1]) op(0, 0, 8'h0, 8'h0, 4'h0, 8'h0, 8'h0, 4'h0, 0);
    pv[0] = 1; pa[0] = 8'h11; pb[0] = 8'h22; ps[0] = 4'h0;
    drive();
    rsp_ready = 1;
    @(negedge clk);
    rst = 1;
    pv[0] = 0;
    drive();
    @(negedge clk);
    rst = 0;
    rsp_ready = 0;
    cnt = '{0, 0}; last = 1;
    chk("mid_busy", busy, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_abs", {A, B, SEL}, 0);
    chk_cnt("mid");
    op(1, 1, 8'h40, 8'h41, 4'h0, 8'h50, 8'h51, 4'h0, 0);
    op(0, 0, 8'h0, 8'h0, 4'h0, 8'h0, 8'h0, 4'h0, 1);
    for (int k = 0; k < 4; k++) op(1, 0, 8'(k), 8'h80, 4'h0, 8'h0, 8'h0, 4'h0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
